// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Operand fetch stage. Decodes source/destination registers of the
//             incoming instruction, reads the register file, bypasses a
//             same-cycle writeback, stalls on outstanding destination writes
//             tracked in a busy scoreboard, and presents the instruction with
//             its operands through a one-entry valid/ready output register.
//  Ports    : clk, rst                      clock, async active-high reset
//             in_valid/in_ready/in_instr    upstream handshake and instruction
//             rf_read_address_0/1           combinational RF read addresses
//             rf_read_data_0/1              combinational RF read data
//             wb_valid/wb_address/wb_data   writeback (also the RF write port)
//             out_valid/out_ready           downstream handshake
//             out_instr/out_rs1_data/out_rs2_data/out_rd/out_writes_rd
//                                           registered instruction + operands
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic [4:0]  rf_read_address_0,
   output logic [4:0]  rf_read_address_1,
   input  logic [31:0] rf_read_data_0,
   input  logic [31:0] rf_read_data_1,
   input  logic        wb_valid,
   input  logic [4:0]  wb_address,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_rs1_data,
   output logic [31:0] out_rs2_data,
   output logic [4:0]  out_rd,
   output logic        out_writes_rd
);

   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_REG    = 7'b0110011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

   // Field extraction
   logic [6:0]  w_opcode;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;

   assign w_opcode = in_instr[6:0];
   assign w_rd     = in_instr[11:7];
   assign w_rs1    = in_instr[19:15];
   assign w_rs2    = in_instr[24:20];

   assign rf_read_address_0 = w_rs1;
   assign rf_read_address_1 = w_rs2;

   // Operand usage decode
   logic w_rs1_used;
   logic w_rs2_used;
   logic w_writes_rd;

   assign w_rs1_used  = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                          (w_opcode == c_OP_JAL));
   assign w_rs2_used  = (w_opcode == c_OP_REG) || (w_opcode == c_OP_STORE) ||
                        (w_opcode == c_OP_BRANCH);
   assign w_writes_rd = !((w_opcode == c_OP_STORE) || (w_opcode == c_OP_BRANCH)) &&
                        (w_rd != 5'd0);

   // Busy scoreboard; x0 can never be busy so only bits 31..1 are stored.
   logic [31:1] r_busy;
   logic [31:0] w_busy;

   assign w_busy = {r_busy, 1'b0};

   // Writeback bypass and operand select
   logic        w_wb_hit_rs1;
   logic        w_wb_hit_rs2;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;

   assign w_wb_hit_rs1 = wb_valid && (wb_address == w_rs1);
   assign w_wb_hit_rs2 = wb_valid && (wb_address == w_rs2);

   assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                       w_wb_hit_rs1    ? wb_data : rf_read_data_0;
   assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                       w_wb_hit_rs2    ? wb_data : rf_read_data_1;

   // A busy source is not a hazard when its writeback arrives this cycle.
   logic w_hazard_rs1;
   logic w_hazard_rs2;

   assign w_hazard_rs1 = w_rs1_used && w_busy[w_rs1] && !w_wb_hit_rs1;
   assign w_hazard_rs2 = w_rs2_used && w_busy[w_rs2] && !w_wb_hit_rs2;

   // Handshake; in_ready deliberately excludes in_valid.
   logic w_accept;

   assign in_ready = (!out_valid || out_ready) && !w_hazard_rs1 && !w_hazard_rs2;
   assign w_accept = in_valid && in_ready;

   // Scoreboard set/clear vectors (bit i corresponds to register i)
   logic [31:1] w_busy_set;
   logic [31:1] w_busy_clr;

   assign w_busy_set = (w_accept && w_writes_rd) ? (31'd1 << (w_rd - 5'd1)) : 31'd0;
   assign w_busy_clr = (wb_valid && (wb_address != 5'd0)) ?
                       (31'd1 << (wb_address - 5'd1)) : 31'd0;

   // Clear first, then set, so a same-cycle set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
      end
   end

   // Output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_instr     <= 32'd0;
         out_rs1_data  <= 32'd0;
         out_rs2_data  <= 32'd0;
         out_rd        <= 5'd0;
         out_writes_rd <= 1'b0;
      end else if (w_accept) begin
         out_valid     <= 1'b1;
         out_instr     <= in_instr;
         out_rs1_data  <= w_rs1_data;
         out_rs2_data  <= w_rs2_data;
         out_rd        <= w_rd;
         out_writes_rd <= w_writes_rd;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

endmodule
`default_nettype wire
